// File: rtl/unidad_es.sv
// CPU I/O unit: four sampled input ports and a {port,data} output FIFO.
// Optional IO_IN_SYNC_EN puts a 2-flop synchronizer on every input port.
module unidad_es #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          ovf,
  input  logic [4*DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_port,
  output logic [DW-1:0] out_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  logic [DW-1:0] samp [4];
`ifdef IO_IN_SYNC_EN
  logic [DW-1:0] meta [4];
`endif

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = we & ~full;
  assign pop       = out_valid & out_ready;
  assign out_port  = mem[rptr].port;
  assign out_data  = mem[rptr].data;

  // Storage is left unreset; it is only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wptr] <= '{port: addr, data: wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (we && full)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
      for (int i = 0; i < 4; i++) begin
        samp[i] <= '0;
`ifdef IO_IN_SYNC_EN
        meta[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef IO_IN_SYNC_EN
        meta[i] <= in_data[i*DW +: DW];
        samp[i] <= meta[i];
`else
        samp[i] <= in_data[i*DW +: DW];
`endif
      end
      if (re)
        rdata <= samp[addr];
    end
  end

endmodule

// File: tb/tb_unidad_es.sv
// Directed self-checking bench for unidad_es (DW=8, DEPTH=4).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_unidad_es;

  localparam int DW = 8;
`ifdef IO_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [1:0]    addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          full;
  logic          ovf;
  logic [4*DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_port;
  logic [DW-1:0] out_data;

  int n_chk = 0;
  int n_fail = 0;

  unidad_es #(.DW(DW), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .full(full), .ovf(ovf),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    we = 1'b1;
    wdata = 8'hEE;
    do_reset();
    we = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b want 0", out_valid);
    end
    n_chk++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full got %b want 0", full);
    end
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ovf got %b want 0", ovf);
    end
    n_chk++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_rdata got %h want 00", rdata);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    we = 1'b1;
    addr = 2'd2;
    wdata = 8'hA5;
    step();
    we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({out_valid, out_port, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
        n_fail++;
        $display("FAIL single_hold%0d got v=%b p=%0d d=%h want v=1 p=2 d=a5",
                 k, out_valid, out_port, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_full_ovf();
    out_ready = 1'b0;
    we = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      addr = 2'(k);
      wdata = 8'(k);
      step();
    end
    n_chk++;
    if ({full, ovf} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_set got full=%b ovf=%b want 1 0", full, ovf);
    end
    wdata = 8'h05;
    step();
    n_chk++;
    if ({full, ovf, out_data} !== {2'b11, 8'h01}) begin
      n_fail++;
      $display("FAIL ovf_set got full=%b ovf=%b d=%h want 1 1 01",
               full, ovf, out_data);
    end
    // full + write + pop: pop happens, write is dropped
    wdata = 8'h06;
    out_ready = 1'b1;
    step();
    we = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      n_chk++;
      if ({out_valid, out_port, out_data} !== {1'b1, 2'(k), 8'(k)}) begin
        n_fail++;
        $display("FAIL drain%0d got v=%b p=%0d d=%h want v=1 p=%0d d=%h",
                 k, out_valid, out_port, out_data, k & 3, k);
      end
      step();
    end
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, full, ovf} !== 3'b001) begin
      n_fail++;
      $display("FAIL drain_end got v=%b full=%b ovf=%b want 0 0 1",
               out_valid, full, ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    we = 1'b1;
    addr = 2'd3;
    wdata = 8'h10;
    step();
    wdata = 8'h11;
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wdata = 8'(8'h12 + k);
      n_chk++;
      if ({out_valid, out_data} !== {1'b1, 8'(8'h10 + k)}) begin
        n_fail++;
        $display("FAIL b2b%0d got v=%b d=%h want v=1 d=%h",
                 k, out_valid, out_data, 8'h10 + k);
      end
      step();
    end
    we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({out_valid, out_data} !== {1'b1, 8'(8'h1A + k)}) begin
        n_fail++;
        $display("FAIL b2b_tail%0d got v=%b d=%h want v=1 d=%h",
                 k, out_valid, out_data, 8'h1A + k);
      end
      step();
    end
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, full, ovf} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_end got v=%b full=%b ovf=%b want 0 0 0",
               out_valid, full, ovf);
    end
  endtask

  task automatic test_read();
    in_data = {8'h33, 8'h22, 8'h3C, 8'h11};
    step();
    step();
    step();
    re = 1'b1;
    we = 1'b1;
    addr = 2'd1;
    wdata = 8'h44;
    step();
    re = 1'b0;
    we = 1'b0;
    n_chk++;
    if (rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_p1 got %h want 3c", rdata);
    end
    n_chk++;
    if ({out_valid, out_port, out_data} !== {1'b1, 2'd1, 8'h44}) begin
      n_fail++;
      $display("FAIL read_wr got v=%b p=%0d d=%h want v=1 p=1 d=44",
               out_valid, out_port, out_data);
    end
    out_ready = 1'b1;
    in_data[15:8] = 8'h99;
    step();
    out_ready = 1'b0;
    step();
    step();
    n_chk++;
    if (rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_hold got %h want 3c", rdata);
    end
    re = 1'b1;
    addr = 2'd3;
    step();
    n_chk++;
    if (rdata !== 8'h33) begin
      n_fail++;
      $display("FAIL read_p3 got %h want 33", rdata);
    end
    // latency: re held on port 2 while port 2 changes
    addr = 2'd2;
    step();
    in_data[23:16] = 8'h5A;
    for (int k = 1; k < LAT; k++)
      step();
    n_chk++;
    if (rdata !== 8'h22) begin
      n_fail++;
      $display("FAIL read_early got %h want 22", rdata);
    end
    step();
    re = 1'b0;
    n_chk++;
    if (rdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL read_lat got %h want 5a", rdata);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    we = 1'b1;
    for (int k = 0; k < 5; k++) begin
      addr = 2'd0;
      wdata = 8'(8'hC0 + k);
      step();
    end
    we = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, full, ovf, out_data} !== {3'b101, 8'hC1}) begin
      n_fail++;
      $display("FAIL mid_pre got v=%b full=%b ovf=%b d=%h want 1 0 1 c1",
               out_valid, full, ovf, out_data);
    end
    do_reset();
    n_chk++;
    if ({out_valid, full, ovf, rdata} !== {3'b000, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_rst got v=%b full=%b ovf=%b rd=%h want 0 0 0 00",
               out_valid, full, ovf, rdata);
    end
    we = 1'b1;
    addr = 2'd1;
    wdata = 8'h77;
    step();
    we = 1'b0;
    n_chk++;
    if ({out_valid, out_port, out_data} !== {1'b1, 2'd1, 8'h77}) begin
      n_fail++;
      $display("FAIL mid_new got v=%b p=%0d d=%h want v=1 p=1 d=77",
               out_valid, out_port, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_only got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_single();
    test_full_ovf();
    test_back_to_back();
    test_read();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
